flash_phy_prog_xex: RTL
=======================

# flash_phy_prog_xex

Program-path XEX sequencer for one flash bank. It sits upstream of `flash_phy_scramble` and downstream of the program data path. For each program word it takes plaintext and address and obtains the Galois mask from the scrambler. It then issues the cipher operation on `plain ^ mask`, forms `scrambled ^ mask`, and presents the result to the flash program interface with a valid/ready handshake. When scrambling is not enabled for the word, it forwards the word unmodified.

## Interface
Parameters:
- `DataWidth`, `flash_phy_pkg::DataWidth`, program word width.
- `BankAddrW`, `flash_phy_pkg::BankAddrW`, bank word-address width.

Ports:
- `clk_i`  in  1  clock; single clock domain.
- `rst_ni`  in  1  reset; asynchronous, active-low.
- `req_i`  in  1  program word request; level, held until `ack_o`.
- `scramble_en_i`  in  1  scrambling enable for this word; sampled at accept.
- `addr_i`  in  BankAddrW  word address; sampled at accept.
- `data_i`  in  DataWidth  plaintext word; sampled at accept.
- `ack_o`  out  1  one-cycle pulse when the word is handed to flash.
- `calc_req_o`  out  1  mask calculation request to the scrambler.
- `calc_ack_i`  in  1  mask calculation done.
- `mask_i`  in  DataWidth  GF mask from the scrambler.
- `op_req_o`  out  1  cipher request to the scrambler.
- `op_type_o`  out  cipher_ops_e  constant `ScrambleOp`.
- `op_addr_o`  out  BankAddrW  captured address.
- `plain_data_o`  out  DataWidth  `data_q ^ mask_q`.
- `op_ack_i`  in  1  cipher done.
- `scrambled_data_i`  in  DataWidth  cipher output.
- `prog_valid_o`  out  1  program word valid to flash.
- `prog_ready_i`  in  1  flash accepts word.
- `prog_data_o`  out  DataWidth  final program word.

## Operation
- States (`prog_xex_state_e`): StIdle, StCalc, StCipher, StOut.
- StIdle: on `req_i`, capture `addr_i`, `data_i`, `scramble_en_i` into `addr_q`, `data_q`, `en_q`.
  - If `scramble_en_i`=1, go to StCalc.
  - Otherwise load `out_q <= data_i` and go to StOut.
- StCalc: `calc_req_o`=1. On `calc_ack_i`, capture `mask_q <= mask_i` and go to StCipher.
- StCipher: `op_req_o`=1 and `plain_data_o = data_q ^ mask_q`. On `op_ack_i`, load `out_q <= scrambled_data_i ^ mask_q` and go to StOut.
- StOut: `prog_valid_o`=1 and `prog_data_o = out_q`. On `prog_ready_i`, `ack_o`=1 and go to StIdle.
- `req_i` is ignored outside StIdle. Input changes after accept have no effect.
- `calc_req_o` and `op_req_o` stay high until their ack, and drop in the cycle after the ack. This matches the scrambler's `!req || req && ack` key-hold rule.
- Acks arriving in a state other than their own are ignored.
- `calc_ack_i` and `op_ack_i` are never asserted together. If they are, only the ack belonging to the current state is acted on.
- `prog_valid_o`, once high, stays high and `out_q` holds until `prog_ready_i`.

## Timing
- Reset values: all outputs 0, state StIdle. `data_q`, `mask_q` and `out_q` reset to 0.
- Bypass latency: accept at cycle N, `prog_valid_o` at N+1. With `prog_ready_i`=1, `ack_o` at N+1.
- Scrambled latency: accept at N, `calc_req_o` from N+1. If the ack arrives at cycle C, `op_req_o` runs from C+1. If the cipher ack arrives at cycle P, `prog_valid_o` rises at P+1.
- Back-to-back: the next `req_i` is accepted no earlier than the cycle after `ack_o`, leaving a one-cycle bubble in StIdle.
- Reset asserted mid-operation: the block returns immediately to StIdle and all outputs go to 0. The in-flight word is dropped without `ack_o`.
- XOR operations are bitwise at full `DataWidth`. There is no arithmetic carry.

## Configuration
- `FLASH_PHY_PROG_XEX_CNT_EN` defined:
  - Adds output `scr_cnt_o` (16 bits).
  - Counts words completed (`ack_o`) with `en_q`=1.
  - Saturates at 16'hFFFF and resets to 0.
- Undefined: the port and counter are absent. Behaviour is otherwise identical.

## Structure
- `flash_phy_pkg` holds `DataWidth`, `BankAddrW`, `cipher_ops_e` and the new `prog_xex_state_e`, a 2-bit enum.
- No sub-module. The FSM, capture registers and XOR logic are inline. `flash_phy_scramble` is instantiated by the parent, not inside this block.

## Test plan
- Bypass: `req_i`=1, `scramble_en_i`=0, `data_i`=64'h0123_4567_89AB_CDEF, `prog_ready_i`=1 -> `prog_data_o`=64'h0123_4567_89AB_CDEF and `ack_o` one cycle after accept. `calc_req_o` and `op_req_o` never rise.
- Scramble: `mask_i`=64'hFFFF_0000_FFFF_0000, `data_i`=64'h1111_1111_1111_1111 -> `plain_data_o`=64'hEEEE_1111_EEEE_1111.
  - Then with `scrambled_data_i`=64'hA5A5_A5A5_A5A5_A5A5 -> `prog_data_o`=64'h5A5A_A5A5_5A5A_A5A5.
- Backpressure: hold `prog_ready_i`=0 for 5 cycles -> `prog_valid_o` stays high and `prog_data_o` is stable. `ack_o` pulses on the cycle `prog_ready_i` is 1.
- Input change after accept: change `data_i` and `addr_i` during StCalc -> `op_addr_o` and `plain_data_o` reflect the captured values.
- Reset during StCipher: assert `rst_ni`=0 -> all outputs 0 within the same cycle, with no `ack_o`. After release, a new request completes normally.
- With `FLASH_PHY_PROG_XEX_CNT_EN`: 3 scrambled words and 2 bypass words -> `scr_cnt_o`=3.

Source files
------------

// File: rtl/flash_phy_pkg.sv
// Shared flash PHY types and widths used by the program-path XEX sequencer.
package flash_phy_pkg;

    localparam int DataWidth = 64;
    localparam int BankAddrW = 16;

    typedef enum logic {
        ScrambleOp   = 1'b0,
        DeScrambleOp = 1'b1
    } cipher_ops_e;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StCalc   = 2'd1,
        StCipher = 2'd2,
        StOut    = 2'd3
    } prog_xex_state_e;

endpackage

// File: rtl/flash_phy_prog_xex.sv
// Program-path XEX sequencer for one flash bank.
// For each accepted word: fetch the GF mask, encrypt (plain ^ mask), then
// present (scrambled ^ mask) to flash. Words with scrambling disabled are
// forwarded unmodified.
// Optional build macro FLASH_PHY_PROG_XEX_CNT_EN adds scr_cnt_o, a saturating
// 16-bit count of completed scrambled words.
module flash_phy_prog_xex
    import flash_phy_pkg::*;
#(
    parameter int DataWidth = flash_phy_pkg::DataWidth,
    parameter int BankAddrW = flash_phy_pkg::BankAddrW
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 req_i,
    input  logic                 scramble_en_i,
    input  logic [BankAddrW-1:0] addr_i,
    input  logic [DataWidth-1:0] data_i,
    output logic                 ack_o,
    output logic                 calc_req_o,
    input  logic                 calc_ack_i,
    input  logic [DataWidth-1:0] mask_i,
    output logic                 op_req_o,
    output cipher_ops_e          op_type_o,
    output logic [BankAddrW-1:0] op_addr_o,
    output logic [DataWidth-1:0] plain_data_o,
    input  logic                 op_ack_i,
    input  logic [DataWidth-1:0] scrambled_data_i,
    output logic                 prog_valid_o,
    input  logic                 prog_ready_i,
    output logic [DataWidth-1:0] prog_data_o
`ifdef FLASH_PHY_PROG_XEX_CNT_EN
    ,
    output logic [15:0]          scr_cnt_o
`endif
);

    prog_xex_state_e      state_q, state_d;
    logic [BankAddrW-1:0] addr_q;
    logic [DataWidth-1:0] data_q, mask_q, out_q;

    // State register; reset drops any in-flight word.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_q <= StIdle;
        else         state_q <= state_d;
    end

    // Next-state: each ack only matters in its own state.
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:   if (req_i)        state_d = scramble_en_i ? StCalc : StOut;
            StCalc:   if (calc_ack_i)   state_d = StCipher;
            StCipher: if (op_ack_i)     state_d = StOut;
            StOut:    if (prog_ready_i) state_d = StIdle;
            default:                    state_d = StIdle;
        endcase
    end

    // Outputs decoded from state; requests hold until the cycle after their ack.
    always_comb begin
        calc_req_o   = 1'b0;
        op_req_o     = 1'b0;
        prog_valid_o = 1'b0;
        ack_o        = 1'b0;
        case (state_q)
            StCalc:   calc_req_o = 1'b1;
            StCipher: op_req_o   = 1'b1;
            StOut: begin
                prog_valid_o = 1'b1;
                ack_o        = prog_ready_i;
            end
            default: ;
        endcase
    end

    // Capture registers: inputs sampled only at accept, mask and result on acks.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            addr_q <= '0;
            data_q <= '0;
            mask_q <= '0;
            out_q  <= '0;
        end else begin
            case (state_q)
                StIdle: if (req_i) begin
                    addr_q <= addr_i;
                    data_q <= data_i;
                    if (!scramble_en_i) out_q <= data_i;
                end
                StCalc:   if (calc_ack_i) mask_q <= mask_i;
                StCipher: if (op_ack_i)   out_q  <= scrambled_data_i ^ mask_q;
                default: ;
            endcase
        end
    end

    assign op_type_o    = ScrambleOp;
    assign op_addr_o    = addr_q;
    assign plain_data_o = data_q ^ mask_q;
    assign prog_data_o  = out_q;

`ifdef FLASH_PHY_PROG_XEX_CNT_EN
    logic        en_q;
    logic [15:0] cnt_q;

    // Remember whether the in-flight word is scrambled.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)                    en_q <= 1'b0;
        else if (state_q == StIdle && req_i) en_q <= scramble_en_i;
    end

    // Saturating count of completed scrambled words.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)                                 cnt_q <= '0;
        else if (ack_o && en_q && cnt_q != 16'hFFFF) cnt_q <= cnt_q + 16'd1;
    end

    assign scr_cnt_o = cnt_q;
`endif

endmodule
